// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready issue and an iterative shift-add multiplier.
// Single-cycle ops: capture on the accept edge, result on the next edge. MUL holds i_ready low for WIDTH cycles.
module alu_pipe #(
    parameter int WIDTH   = 16,
    parameter int RD_BITS = 4,
    parameter int PC_IDX  = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_valid,
    output logic               i_ready,
    input  logic [WIDTH-1:0]   opr_a,
    input  logic [WIDTH-1:0]   opr_b,
    input  logic [3:0]         alu_op,
    input  logic [RD_BITS-1:0] i_sel_rd,
    input  logic               i_sel_d,
    input  logic               i_ts,
    output logic [WIDTH-1:0]   result,
    output logic               o_valid,
    output logic               wr_pc,
    output logic               wr_reg,
    output logic               wr_qp,
    output logic               o_ts,
    output logic [RD_BITS-1:0] o_sel_rd,
    output logic [3:0]         flags
);
    localparam int SH = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR = 4'h3,
                           OP_XOR = 4'h4, OP_SHL = 4'h5, OP_SHR = 4'h6, OP_SAR = 4'h7,
                           OP_MUL = 4'h8, OP_CEQ = 4'h9, OP_CLT = 4'hA, OP_CLTU = 4'hB,
                           OP_PASSB = 4'hC;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t               state_q, state_d;
    logic [SH-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
    logic                 s1_vld_q, s1_vld_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
    logic [3:0]           op_q, op_d;
    logic [RD_BITS-1:0]   rd_q, rd_d;
    logic                 seld_q, seld_d, ts_q, ts_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 o_valid_q, o_valid_d, wr_pc_q, wr_pc_d, wr_reg_q, wr_reg_d;
    logic                 wr_qp_q, wr_qp_d, o_ts_q, o_ts_d;
    logic [RD_BITS-1:0]   o_sel_rd_q, o_sel_rd_d;
    logic [3:0]           flags_q, flags_d;

    logic                 accept, mul_done, comp_vld;
    logic [SH-1:0]        amt;
    logic [WIDTH:0]       sum, dif, shl, shr;
    logic signed [WIDTH:0] sar_in, sar;
    logic [WIDTH-1:0]     acc_step, res_c, nz_src;
    logic                 c_c, v_c, cmp_c, wr_ok, flag_ok, is_cmp, v_add, v_sub;

    assign i_ready  = (state_q == S_IDLE);
    assign accept   = i_valid && i_ready;
    assign mul_done = (state_q == S_BUSY) && (cnt_q == '0);
    assign comp_vld = s1_vld_q || mul_done;

    always_comb begin
        amt      = b_q[SH-1:0];
        sum      = {1'b0, a_q} + {1'b0, b_q};
        dif      = {1'b0, a_q} - {1'b0, b_q};
        shl      = {1'b0, a_q} << amt;
        shr      = {a_q, 1'b0} >> amt;
        sar_in   = {a_q, 1'b0};
        sar      = sar_in >>> amt;
        v_add    = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
        v_sub    = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (dif[WIDTH-1] != a_q[WIDTH-1]);
        acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

        res_c   = '0;
        c_c     = 1'b0;
        v_c     = 1'b0;
        cmp_c   = 1'b0;
        wr_ok   = 1'b1;
        flag_ok = 1'b1;
        is_cmp  = 1'b0;
        case (op_q)
            OP_ADD:   begin res_c = sum[WIDTH-1:0]; c_c = sum[WIDTH]; v_c = v_add; end
            OP_SUB:   begin res_c = dif[WIDTH-1:0]; c_c = ~dif[WIDTH]; v_c = v_sub; end
            OP_AND:   res_c = a_q & b_q;
            OP_OR:    res_c = a_q | b_q;
            OP_XOR:   res_c = a_q ^ b_q;
            OP_SHL:   begin res_c = shl[WIDTH-1:0]; c_c = shl[WIDTH]; end
            OP_SHR:   begin res_c = shr[WIDTH:1]; c_c = shr[0]; end
            OP_SAR:   begin res_c = sar[WIDTH:1]; c_c = sar[0]; end
            OP_MUL:   res_c = acc_step;
            OP_CEQ, OP_CLT, OP_CLTU: begin
                is_cmp = 1'b1;
                wr_ok  = 1'b0;
                c_c    = ~dif[WIDTH];
                v_c    = v_sub;
                if (op_q == OP_CEQ)
                    cmp_c = (a_q == b_q);
                else if (op_q == OP_CLT)
                    cmp_c = ($signed(a_q) < $signed(b_q));
                else
                    cmp_c = dif[WIDTH];
            end
            OP_PASSB: res_c = b_q;
            default:  begin wr_ok = 1'b0; flag_ok = 1'b0; end
        endcase
        // Compares report N/Z of A-B even though their result is forced to zero
        nz_src = is_cmp ? dif[WIDTH-1:0] : res_c;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        s1_vld_d = 1'b0;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        rd_d     = rd_q;
        seld_d   = seld_q;
        ts_d     = ts_q;
        if (accept) begin
            a_d    = opr_a;
            b_d    = opr_b;
            op_d   = alu_op;
            rd_d   = i_sel_rd;
            seld_d = i_sel_d;
            ts_d   = i_ts;
            if (alu_op == OP_MUL) begin
                state_d  = S_BUSY;
                cnt_d    = SH'(WIDTH - 1);
                mcand_d  = opr_a;
                mplier_d = opr_b;
                acc_d    = '0;
            end else begin
                s1_vld_d = 1'b1;
            end
        end else if (state_q == S_BUSY) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - 1'b1;
            if (cnt_q == '0)
                state_d = S_IDLE;
        end

        o_valid_d  = comp_vld;
        result_d   = comp_vld ? res_c : result_q;
        wr_pc_d    = comp_vld && wr_ok && seld_q && (rd_q == RD_BITS'(PC_IDX));
        wr_reg_d   = comp_vld && wr_ok && seld_q && (rd_q != RD_BITS'(PC_IDX));
        wr_qp_d    = comp_vld && wr_ok && !seld_q;
        o_ts_d     = comp_vld ? (ts_q && cmp_c) : o_ts_q;
        o_sel_rd_d = comp_vld ? rd_q : o_sel_rd_q;
        flags_d    = (comp_vld && flag_ok) ?
                     {nz_src[WIDTH-1], (nz_src == '0), c_c, v_c} : flags_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            s1_vld_q   <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            rd_q       <= '0;
            seld_q     <= 1'b0;
            ts_q       <= 1'b0;
            result_q   <= '0;
            o_valid_q  <= 1'b0;
            wr_pc_q    <= 1'b0;
            wr_reg_q   <= 1'b0;
            wr_qp_q    <= 1'b0;
            o_ts_q     <= 1'b0;
            o_sel_rd_q <= '0;
            flags_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            s1_vld_q   <= s1_vld_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            rd_q       <= rd_d;
            seld_q     <= seld_d;
            ts_q       <= ts_d;
            result_q   <= result_d;
            o_valid_q  <= o_valid_d;
            wr_pc_q    <= wr_pc_d;
            wr_reg_q   <= wr_reg_d;
            wr_qp_q    <= wr_qp_d;
            o_ts_q     <= o_ts_d;
            o_sel_rd_q <= o_sel_rd_d;
            flags_q    <= flags_d;
        end
    end

    assign result   = result_q;
    assign o_valid  = o_valid_q;
    assign wr_pc    = wr_pc_q;
    assign wr_reg   = wr_reg_q;
    assign wr_qp    = wr_qp_q;
    assign o_ts     = o_ts_q;
    assign o_sel_rd = o_sel_rd_q;
    assign flags    = flags_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe at WIDTH=16.
module tb_alu_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        i_ready;
    logic [15:0] opr_a, opr_b;
    logic [3:0]  alu_op;
    logic [3:0]  i_sel_rd;
    logic        i_sel_d, i_ts;
    logic [15:0] result;
    logic        o_valid, wr_pc, wr_reg, wr_qp, o_ts;
    logic [3:0]  o_sel_rd;
    logic [3:0]  flags;

    int n_chk  = 0;
    int n_pass = 0;
    int saw_vld;

    alu_pipe #(.WIDTH(16), .RD_BITS(4), .PC_IDX(15)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready),
        .opr_a(opr_a), .opr_b(opr_b), .alu_op(alu_op), .i_sel_rd(i_sel_rd),
        .i_sel_d(i_sel_d), .i_ts(i_ts), .result(result), .o_valid(o_valid),
        .wr_pc(wr_pc), .wr_reg(wr_reg), .wr_qp(wr_qp), .o_ts(o_ts),
        .o_sel_rd(o_sel_rd), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    // Present one op for one cycle, then wait for the edge that produces its result.
    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] rd, input logic d, input logic ts);
        alu_op = op; opr_a = a; opr_b = b; i_sel_rd = rd; i_sel_d = d; i_ts = ts;
        i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic expect_out(input string tag, input logic [15:0] res,
                              input logic [2:0] wr, input logic [3:0] flg);
        check({tag, ".vld"}, {31'b0, o_valid}, 32'd1);
        check({tag, ".res"}, {16'b0, result}, {16'b0, res});
        check({tag, ".wr"}, {29'b0, wr_pc, wr_reg, wr_qp}, {29'b0, wr});
        check({tag, ".flg"}, {28'b0, flags}, {28'b0, flg});
    endtask

    initial begin
        rst = 1'b1; i_valid = 1'b0; opr_a = '0; opr_b = '0; alu_op = '0;
        i_sel_rd = '0; i_sel_d = 1'b0; i_ts = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.ready", {31'b0, i_ready}, 32'd1);
        check("rst.vld", {31'b0, o_valid}, 32'd0);
        check("rst.res", {16'b0, result}, 32'd0);
        check("rst.misc", {24'b0, wr_pc, wr_reg, wr_qp, o_ts, flags}, 32'd0);
        rst = 1'b0;

        issue(4'h0, 16'h0F0F, 16'hF0F1, 4'd0, 1'b1, 1'b0);
        expect_out("add_wrap", 16'h0000, 3'b010, 4'b0110);
        @(posedge clk); #1;
        check("add_pulse", {31'b0, o_valid}, 32'd0);

        issue(4'h1, 16'h0F0F, 16'hF0F1, 4'd4, 1'b1, 1'b0);
        expect_out("sub", 16'h1E1E, 3'b010, 4'b0000);
        check("sub.rd", {28'b0, o_sel_rd}, 32'd4);

        issue(4'h7, 16'h8000, 16'h0014, 4'd15, 1'b1, 1'b0);
        expect_out("sar", 16'hF800, 3'b100, 4'b1000);
        issue(4'h5, 16'h8001, 16'h0001, 4'd2, 1'b0, 1'b0);
        expect_out("shl", 16'h0002, 3'b001, 4'b0010);
        issue(4'h6, 16'h8001, 16'h0001, 4'd2, 1'b1, 1'b0);
        expect_out("shr", 16'h4000, 3'b010, 4'b0010);
        issue(4'h5, 16'h8001, 16'h0000, 4'd2, 1'b1, 1'b0);
        expect_out("shl0", 16'h8001, 3'b010, 4'b1000);
        issue(4'h0, 16'h7FFF, 16'h0001, 4'd1, 1'b1, 1'b0);
        expect_out("add_ovf", 16'h8000, 3'b010, 4'b1001);

        issue(4'hA, 16'hF0F1, 16'h0F0F, 4'd3, 1'b1, 1'b1);
        expect_out("cmplt", 16'h0000, 3'b000, 4'b1010);
        check("cmplt.ts", {31'b0, o_ts}, 32'd1);
        issue(4'hA, 16'hF0F1, 16'h0F0F, 4'd3, 1'b1, 1'b0);
        check("cmplt_nots.ts", {31'b0, o_ts}, 32'd0);
        issue(4'hB, 16'h0F0F, 16'hF0F1, 4'd3, 1'b1, 1'b1);
        expect_out("cmpltu", 16'h0000, 3'b000, 4'b0000);
        check("cmpltu.ts", {31'b0, o_ts}, 32'd1);
        issue(4'h9, 16'h1234, 16'h1234, 4'd3, 1'b1, 1'b1);
        expect_out("cmpeq", 16'h0000, 3'b000, 4'b0110);
        check("cmpeq.ts", {31'b0, o_ts}, 32'd1);

        issue(4'h4, 16'h0F0F, 16'hF0F1, 4'd5, 1'b1, 1'b1);
        expect_out("xor", 16'hFFFE, 3'b010, 4'b1000);
        check("xor.ts", {31'b0, o_ts}, 32'd0);
        issue(4'h2, 16'h0F0F, 16'hF0F1, 4'd5, 1'b1, 1'b0);
        expect_out("and", 16'h0001, 3'b010, 4'b0000);
        issue(4'h3, 16'h0F0F, 16'hF0F1, 4'd5, 1'b1, 1'b0);
        expect_out("or", 16'hFFFF, 3'b010, 4'b1000);
        issue(4'hC, 16'hFFFF, 16'h0000, 4'd6, 1'b0, 1'b0);
        expect_out("passb", 16'h0000, 3'b001, 4'b0100);
        issue(4'hD, 16'hFFFF, 16'hFFFF, 4'd6, 1'b1, 1'b1);
        expect_out("rsvd", 16'h0000, 3'b000, 4'b0100);
        check("rsvd.ts", {31'b0, o_ts}, 32'd0);

        // Back-to-back issue: two ADDs on consecutive edges
        alu_op = 4'h0; opr_a = 16'd1; opr_b = 16'd1; i_sel_rd = 4'd7; i_sel_d = 1'b1;
        i_ts = 1'b0; i_valid = 1'b1;
        @(posedge clk); #1;
        opr_a = 16'd2; opr_b = 16'd2;
        @(posedge clk); #1;
        i_valid = 1'b0;
        expect_out("b2b_1", 16'd2, 3'b010, 4'b0000);
        @(posedge clk); #1;
        expect_out("b2b_2", 16'd4, 3'b010, 4'b0000);

        // MUL with a second request held valid during the busy window
        alu_op = 4'h8; opr_a = 16'h0F0F; opr_b = 16'h7FF1; i_sel_rd = 4'd9; i_valid = 1'b1;
        @(posedge clk); #1;
        check("mul.busy0", {31'b0, i_ready}, 32'd0);
        alu_op = 4'h0; opr_a = 16'd1; opr_b = 16'd2; i_sel_rd = 4'd8;
        saw_vld = 0;
        for (int k = 1; k < 16; k++) begin
            @(posedge clk); #1;
            if (o_valid || i_ready) saw_vld++;
        end
        check("mul.early", saw_vld, 32'd0);
        @(posedge clk); #1;
        expect_out("mul", 16'h9E1F, 3'b010, 4'b1000);
        check("mul.rd", {28'b0, o_sel_rd}, 32'd9);
        check("mul.ready", {31'b0, i_ready}, 32'd1);
        @(posedge clk); #1;
        i_valid = 1'b0;
        check("mul.pulse", {31'b0, o_valid}, 32'd0);
        @(posedge clk); #1;
        expect_out("held_add", 16'd3, 3'b010, 4'b0000);
        check("held_add.rd", {28'b0, o_sel_rd}, 32'd8);

        // Reset in the middle of a MUL aborts it
        alu_op = 4'h8; opr_a = 16'h0003; opr_b = 16'h0005; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mrst.ready", {31'b0, i_ready}, 32'd1);
        check("mrst.out", {result, 8'b0, o_valid, wr_pc, wr_reg, wr_qp, o_ts, 3'b0},
              32'd0);
        check("mrst.flg", {24'b0, o_sel_rd, flags}, 32'd0);
        saw_vld = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (o_valid) saw_vld++;
        end
        check("mrst.novld", saw_vld, 32'd0);
        issue(4'h0, 16'h1000, 16'h0234, 4'd15, 1'b1, 1'b0);
        expect_out("post_rst", 16'h1234, 3'b100, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
